tt_vector_checker: RTL and testbench

Self-checking stimulus driver for the 4-input combinational function blocks in the W2 exercises. On `start` it walks the 4-bit input vector {a,b,c,d} through 0..15, holds each value for a programmable settle time, samples the function-under-test output, and assembles the observed 16-bit truth table (signature). It then compares the signature against an expected table and reports pass/fail, error count and first failing vector. It sits on the driving side of a function block: `vec` feeds the block's inputs and the block's output returns on `dut_f`.

---
 rtl/tt_vector_checker.sv | 154 +++++++++++++++
 tb/tb_tt_vector_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tt_vector_checker.sv
// tt_vector_checker
// Drives the 4-bit input vector {a,b,c,d} of a combinational function block
// through 0..15, samples the block's output after a programmable settle time,
// builds the observed truth table and compares it to an expected table.
//
// Parameters:
//   EXPECTED  expected truth table, bit k = required dut_f for vec = k
//   SETTLE    cycles each vector is held before it is sampled (1..15)
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   start           begin a run (ignored while sweeping)
//   vec             vector driven to the block under test, vec[3]=a .. vec[0]=d
//   dut_f           output of the block under test
//   busy            high while sweeping
//   done            high when results are valid
//   pass            signature matched EXPECTED (valid with done)
//   signature       observed truth table
//   err_count       number of mismatching vectors
//   first_err       lowest mismatching vector index
//   first_err_valid a mismatch has been recorded
module tt_vector_checker #(
  parameter logic [15:0] EXPECTED = 16'hCFF3,
  parameter int unsigned SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  vec,
  input  logic        dut_f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        first_err_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  vec_r;
  logic [15:0] signature_r;
  logic [15:0] sig_nxt_s;
  logic [4:0]  err_count_r;
  logic [3:0]  first_err_r;
  logic        first_err_valid_r;
  logic        pass_r;
  logic        busy_r;
  logic        done_r;
  logic        sample_s;
  logic        start_ok_s;
  logic        mismatch_s;

  // Sample strobe, restart qualifier and the signature with the current bit merged in.
  always_comb begin
    sample_s   = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    start_ok_s = start && (state_r != ST_RUN);
    mismatch_s = (dut_f != EXPECTED[vec_r]);
    sig_nxt_s  = signature_r;
    sig_nxt_s[vec_r] = dut_f;
  end

  // Next-state logic of the sweep controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (sample_s && (vec_r == 4'd15)) state_nxt_s = ST_DONE;
        else                              state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Sweep datapath: vector/settle counters and result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r             <= 4'd0;
      vec_r             <= 4'd0;
      signature_r       <= 16'd0;
      err_count_r       <= 5'd0;
      first_err_r       <= 4'd0;
      first_err_valid_r <= 1'b0;
      pass_r            <= 1'b0;
    end else if (start_ok_s) begin
      cnt_r             <= 4'd0;
      vec_r             <= 4'd0;
      signature_r       <= 16'd0;
      err_count_r       <= 5'd0;
      first_err_r       <= 4'd0;
      first_err_valid_r <= 1'b0;
      pass_r            <= 1'b0;
    end else if (sample_s) begin
      signature_r <= sig_nxt_s;
      cnt_r       <= 4'd0;
      if (mismatch_s) begin
        err_count_r <= err_count_r + 5'd1;
        if (!first_err_valid_r) begin
          first_err_r       <= vec_r;
          first_err_valid_r <= 1'b1;
        end
      end
      // Last vector: vec stays at 15 and pass uses the signature including this sample.
      if (vec_r == 4'd15) begin
        pass_r <= (sig_nxt_s == EXPECTED);
      end else begin
        vec_r <= vec_r + 4'd1;
      end
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  assign vec             = vec_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign signature       = signature_r;
  assign err_count       = err_count_r;
  assign first_err       = first_err_r;
  assign first_err_valid = first_err_valid_r;

endmodule

// File: tb/tb_tt_vector_checker.sv
// Testbench for tt_vector_checker: two instances (SETTLE=2 and SETTLE=1)
// driven by truth-table models of the block under test; expected results are
// computed from the table itself (popcount and lowest differing bit).
module tb_tt_vector_checker;

  localparam logic [15:0] EXP = 16'hCFF3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] ft0 = EXP, ft1 = EXP;
  logic [3:0]  vec0, vec1, first_err0, first_err1;
  logic        busy0, busy1, done0, done1, pass0, pass1, fev0, fev1;
  logic [15:0] sig0, sig1;
  logic [4:0]  errc0, errc1;
  logic        dut_f0, dut_f1;

  assign dut_f0 = ft0[vec0];
  assign dut_f1 = ft1[vec1];

  tt_vector_checker #(.EXPECTED(EXP), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec(vec0), .dut_f(dut_f0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0),
    .err_count(errc0), .first_err(first_err0), .first_err_valid(fev0)
  );

  tt_vector_checker #(.EXPECTED(EXP), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec(vec1), .dut_f(dut_f1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1),
    .err_count(errc1), .first_err(first_err1), .first_err_valid(fev1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic [3:0]  o_vec, o_ferr;
  logic        o_busy, o_done, o_pass, o_fev;
  logic [15:0] o_sig;
  logic [4:0]  o_errc;

  always_comb begin
    if (sel == 1) begin
      o_vec = vec1; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_sig = sig1; o_errc = errc1; o_ferr = first_err1; o_fev = fev1;
    end else begin
      o_vec = vec0; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_sig = sig0; o_errc = errc0; o_ferr = first_err0; o_fev = fev0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " vec"}, {28'd0, o_vec}, 32'd0);
    chk({tag, " busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, " done"}, {31'd0, o_done}, 32'd0);
    chk({tag, " pass"}, {31'd0, o_pass}, 32'd0);
    chk({tag, " sig"}, {16'd0, o_sig}, 32'd0);
    chk({tag, " errc"}, {27'd0, o_errc}, 32'd0);
    chk({tag, " ferr"}, {28'd0, o_ferr}, 32'd0);
    chk({tag, " fev"}, {31'd0, o_fev}, 32'd0);
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start1 = v;
    else          start0 = v;
  endtask

  // Full sweep with table ft; start held for 'hold' cycles; checks vec/busy/done every cycle
  // and the final results against the reference computed from ft.
  task automatic run_sweep(input string tag, input logic [15:0] ft, input int hold);
    int s;
    int exp_err;
    int exp_first;
    logic [15:0] diff;
    s = (sel == 1) ? 1 : 2;
    if (sel == 1) ft1 = ft;
    else          ft0 = ft;
    diff = ft ^ EXP;
    exp_err = $countones(diff);
    exp_first = 0;
    for (int k = 15; k >= 0; k--) if (diff[k]) exp_first = k;
    @(negedge clk);
    set_start(1'b1);
    for (int t = 0; t <= 16 * s; t++) begin
      @(negedge clk);
      if (t + 1 == hold) set_start(1'b0);
      if (t == 0) begin
        chk({tag, " clr sig"}, {16'd0, o_sig}, 32'd0);
        chk({tag, " clr errc"}, {27'd0, o_errc}, 32'd0);
        chk({tag, " clr pass"}, {31'd0, o_pass}, 32'd0);
        chk({tag, " clr fev"}, {31'd0, o_fev}, 32'd0);
      end
      if (t < 16 * s) begin
        chk({tag, " vec"}, {28'd0, o_vec}, 32'(t / s));
        chk({tag, " busy"}, {31'd0, o_busy}, 32'd1);
        chk({tag, " done"}, {31'd0, o_done}, 32'd0);
      end else begin
        chk({tag, " done@end"}, {31'd0, o_done}, 32'd1);
        chk({tag, " busy@end"}, {31'd0, o_busy}, 32'd0);
        chk({tag, " vec@end"}, {28'd0, o_vec}, 32'd15);
      end
    end
    set_start(1'b0);
    chk({tag, " sig"}, {16'd0, o_sig}, {16'd0, ft});
    chk({tag, " errc"}, {27'd0, o_errc}, 32'(exp_err));
    chk({tag, " fev"}, {31'd0, o_fev}, (exp_err != 0) ? 32'd1 : 32'd0);
    if (exp_err != 0) chk({tag, " ferr"}, {28'd0, o_ferr}, 32'(exp_first));
    chk({tag, " pass"}, {31'd0, o_pass}, (ft == EXP) ? 32'd1 : 32'd0);
    // Results must hold while idle in DONE.
    repeat (3) @(negedge clk);
    chk({tag, " hold sig"}, {16'd0, o_sig}, {16'd0, ft});
    chk({tag, " hold done"}, {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    logic [15:0] rnd;
    sel = 0;
    rst_n = 1'b0;
    start0 = 1'b1;  // reset must win over start
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    start0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("idle");

    run_sweep("correct", EXP, 1);
    run_sweep("tied0", 16'h0000, 1);
    run_sweep("inv12", EXP ^ 16'h1000, 1);
    run_sweep("hold10", EXP, 10);

    // Reset mid-run while vec = 7.
    ft0 = EXP;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrun vec7", {28'd0, vec0}, 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrun rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrun idle busy", {31'd0, busy0}, 32'd0);
    run_sweep("after rst", EXP, 1);

    for (int i = 0; i < 3; i++) begin
      rnd = 16'($urandom);
      run_sweep("rand2", rnd, 1);
    end

    sel = 1;
    run_sweep("s1 correct", EXP, 1);
    rnd = 16'($urandom);
    run_sweep("s1 rand", rnd, 1);
    run_sweep("s1 inv0", EXP ^ 16'h0001, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
